rule_scheduler: RTL and testbench
=================================

Name: rule_scheduler

Overview:
- Round-robin scheduler for the generated Murphi `system` rule-enable port `io_en_a`.
- Takes per-rule guard-true flags from the system state and asserts at most one rule enable per cycle.
- Supports free-run and single-step modes, plus starvation and deadlock monitoring.
- Sits between the generated `system` and the simulation/equivalence harness, replacing hand-driven `io_en_a` stimulus.

Parameters:
- N_RULES, 3, number of rules (width of `io_guard` / `io_en_a`).
- WAIT_W, 4, width of each per-rule wait counter.
- STARVE_LIMIT, 8, wait count at or above which a rule is flagged starved.
- DEADLOCK_CYC, 16, consecutive RUN cycles with no true guard before halting.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- io_guard, input, N_RULES, guard of rule i currently true.
- io_run, input, 1, level: free-run request.
- io_step, input, 1, single-cycle pulse: fire one rule while IDLE.
- io_clear, input, 1, pulse: leave HALT and clear monitors.
- io_en_a, output, N_RULES, one-hot or zero rule enable into `system`.
- io_fired, output, 1, `io_en_a` non-zero this cycle.
- io_rule_idx, output, $clog2(N_RULES), index of the fired rule; 0 when none fired.
- io_starved, output, N_RULES, per-rule starvation flag.
- io_deadlock, output, 1, high while in HALT.

Behaviour:
- Reset is asynchronous: all registers clear immediately.
  - state=IDLE, ptr=0, wait counters=0, idle_cnt=0.
  - All outputs are 0 during and after reset until the first qualifying cycle.
- Selection (combinational):
  - cand = first i, scanning ptr, ptr+1, … mod N_RULES, with io_guard[i]=1.
  - io_en_a = onehot(cand) when fire=1, else 0.
  - `io_en_a` is combinational from `io_guard` and registered state. The enabled rule is applied by `system` on the same edge. There is no added latency.
- fire conditions:
  - fire = (state==RUN && |io_guard) || (state==IDLE && io_step && |io_guard).
  - No fire in HALT.
  - A step with all guards false is dropped silently.
- Pointer update: on a fire of rule cand, ptr <= (cand+1) mod N_RULES. Otherwise ptr holds. Wrap from N_RULES-1 goes to 0.
- FSM states: IDLE, RUN, HALT. Transitions are registered.
  - IDLE→RUN when io_run=1; grants begin the next cycle.
  - RUN→IDLE when io_run=0; the current cycle still grants.
  - RUN→HALT when idle_cnt reaches DEADLOCK_CYC-1 and |io_guard==0.
  - HALT→IDLE on io_clear. io_clear has priority over io_run; a held io_run re-enters RUN one cycle later.
  - io_step in RUN or HALT is ignored.
  - io_clear outside HALT clears the monitors only.
- idle_cnt:
  - In RUN: increments when |io_guard==0, resets to 0 on any fire.
  - Held at 0 outside RUN.
- Wait counters: each cycle in IDLE or RUN, per rule:
  - wait[i] increments, saturating at 2^WAIT_W-1, when io_guard[i]=1 and rule i is not fired.
  - wait[i] clears when rule i fires or io_guard[i]=0.
  - wait[i] is frozen in HALT.
  - io_starved[i] = (wait[i] >= STARVE_LIMIT), registered.
- io_deadlock = (state==HALT).
- Reset mid-RUN: io_en_a drops combinationally in the same cycle. No partial state is kept.

Optional Feature:
- Macro: RULE_SCHED_LFSR_EN.
- Defined:
  - Adds a 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advancing every cycle.
  - On each fire, ptr <= lfsr[ $clog2(N_RULES)-1:0 ] mod N_RULES instead of cand+1, giving a randomized interleaving for trace exploration.
  - All other behaviour is unchanged.
- Undefined: strict round-robin as above; no LFSR logic is present.

Test Plan:
- Reset → RUN with io_guard=3'b111 for 4 cycles → io_en_a sequence 001, 010, 100, 001; io_rule_idx 0,1,2,0; io_fired=1 each cycle.
- ptr=1 (after one fire of rule 0), io_guard=3'b101, RUN → io_en_a=100, then ptr=0 → next cycle io_en_a=001.
- IDLE, io_guard=3'b010, io_step pulse for 1 cycle → io_en_a=010 for exactly that cycle, 000 after. io_step with io_guard=000 → io_en_a=000, ptr unchanged.
- DEADLOCK_CYC=4, RUN, io_guard=000 for 4 cycles → io_deadlock=1 from the 5th cycle. io_guard=111 then gives io_en_a=000. io_clear → IDLE, io_deadlock=0 next cycle.
- STARVE_LIMIT=2, RUN, io_guard=3'b111 from ptr=0 → io_starved[2]=1 in cycle 3 (before rule 2 fires), 0 the cycle after its grant.
- RUN with io_guard=111, assert reset asynchronously mid-cycle → io_en_a=000 immediately. After release: state IDLE, ptr=0, io_starved=000.

Source files
------------

// File: rtl/rule_scheduler_if.sv
// ---------------------------------------------------------------------------
// rule_scheduler_if
// Bundles the guard/enable path between the generated Murphi `system`, the
// rule scheduler and the simulation harness.
//
// Signals (directions as seen by the scheduler, modport slave):
//   io_guard    in  [N_RULES]  per-rule guard currently true
//   io_run      in  1          free-run request (level)
//   io_step     in  1          single-step pulse, honoured only in IDLE
//   io_clear    in  1          leave HALT and clear the monitors
//   io_en_a     out [N_RULES]  one-hot or zero rule enable into `system`
//   io_fired    out 1          io_en_a is non-zero this cycle
//   io_rule_idx out [IDX_W]    index of the fired rule, 0 when none fired
//   io_starved  out [N_RULES]  per-rule starvation flag
//   io_deadlock out 1          high while in HALT
//
// Modports: master = harness side (drives guards/controls),
//           slave  = scheduler side.
// ---------------------------------------------------------------------------
interface rule_scheduler_if #(
    parameter int N_RULES = 3
);
    localparam int IDX_W = (N_RULES > 1) ? $clog2(N_RULES) : 1;

    logic [N_RULES-1:0] io_guard;
    logic               io_run;
    logic               io_step;
    logic               io_clear;
    logic [N_RULES-1:0] io_en_a;
    logic               io_fired;
    logic [IDX_W-1:0]   io_rule_idx;
    logic [N_RULES-1:0] io_starved;
    logic               io_deadlock;

    modport master (
        output io_guard, io_run, io_step, io_clear,
        input  io_en_a, io_fired, io_rule_idx, io_starved, io_deadlock
    );

    modport slave (
        input  io_guard, io_run, io_step, io_clear,
        output io_en_a, io_fired, io_rule_idx, io_starved, io_deadlock
    );
endinterface

// File: rtl/rule_scheduler.sv
// ---------------------------------------------------------------------------
// rule_scheduler
// Round-robin scheduler that drives the rule-enable port of the generated
// Murphi `system`. At most one rule is enabled per cycle; the enable is
// combinational from the guards and the registered state so `system` applies
// the chosen rule on the same clock edge.
//
// Modes: IDLE (single-step via io_step), RUN (free-run while io_run is high),
// HALT (entered after DEADLOCK_CYC consecutive RUN cycles with no true guard,
// left with io_clear). Per-rule wait counters flag starvation.
//
// Ports:
//   clock  in  system clock
//   reset  in  asynchronous active-high reset
//   bus    rule_scheduler_if.slave (guards/controls in, enables/monitors out)
//
// Optional build macro: RULE_SCHED_LFSR_EN
//   When defined, a 16-bit Galois LFSR (taps 16,14,13,11, seed 16'hACE1)
//   advances every cycle and, on each fire, reloads the round-robin pointer
//   with lfsr[IDX_W-1:0] mod N_RULES for randomized interleavings. When
//   undefined the scheduler is strict round-robin and has no LFSR.
// ---------------------------------------------------------------------------
module rule_scheduler #(
    parameter int N_RULES      = 3,
    parameter int WAIT_W       = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int DEADLOCK_CYC = 16
) (
    input  logic              clock,
    input  logic              reset,
    rule_scheduler_if.slave   bus
);
    localparam int IDX_W = (N_RULES > 1) ? $clog2(N_RULES) : 1;
    localparam int CNT_W = (DEADLOCK_CYC > 1) ? $clog2(DEADLOCK_CYC) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q [N_RULES];
    logic [WAIT_W-1:0]  wait_cnt_d [N_RULES];
    logic [N_RULES-1:0] starved_q, starved_d;

    logic               any_guard_s;
    logic               found_s;
    logic [IDX_W-1:0]   cand_s;
    logic               fire_s;
    logic [N_RULES-1:0] en_s;
    logic [IDX_W-1:0]   rr_next_s;

`ifdef RULE_SCHED_LFSR_EN
    logic [15:0] lfsr_q;

    // Galois LFSR step, right-shifting, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) begin
            n = n ^ 16'hB400;
        end else begin
            n = n;
        end
        return n;
    endfunction

    // Free-running LFSR state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end
`endif

    // Rotating priority search: first true guard starting at ptr_q.
    always_comb begin
        int idx_v;
        found_s     = 1'b0;
        cand_s      = {IDX_W{1'b0}};
        any_guard_s = |bus.io_guard;
        for (int k = 0; k < N_RULES; k++) begin
            idx_v = int'(ptr_q) + k;
            if (idx_v >= N_RULES) begin
                idx_v = idx_v - N_RULES;
            end else begin
                idx_v = idx_v;
            end
            if (!found_s && bus.io_guard[IDX_W'(idx_v)]) begin
                found_s = 1'b1;
                cand_s  = IDX_W'(idx_v);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Fire decision and one-hot enable; reset blocks any grant immediately.
    always_comb begin
        fire_s = 1'b0;
        en_s   = {N_RULES{1'b0}};
        if (!reset && any_guard_s &&
            ((state_q == ST_RUN) || ((state_q == ST_IDLE) && bus.io_step))) begin
            fire_s       = 1'b1;
            en_s[cand_s] = 1'b1;
        end else begin
            fire_s = 1'b0;
        end
    end

    // Next-state logic for the IDLE/RUN/HALT controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.io_run) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!bus.io_run) begin
                    state_d = ST_IDLE;
                end else if (!any_guard_s &&
                             (idle_cnt_q == CNT_W'(DEADLOCK_CYC - 1))) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (bus.io_clear) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pointer advance on a fire: round-robin successor or LFSR-chosen slot.
    always_comb begin
        if (cand_s == IDX_W'(N_RULES - 1)) begin
            rr_next_s = {IDX_W{1'b0}};
        end else begin
            rr_next_s = cand_s + IDX_W'(1);
        end
        ptr_d = ptr_q;
        if (fire_s) begin
`ifdef RULE_SCHED_LFSR_EN
            ptr_d = IDX_W'(32'(lfsr_q[IDX_W-1:0]) % 32'(N_RULES));
`else
            ptr_d = rr_next_s;
`endif
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Monitors: idle counter for deadlock, per-rule wait counters for starvation.
    always_comb begin
        idle_cnt_d = {CNT_W{1'b0}};
        starved_d  = starved_q;
        for (int i = 0; i < N_RULES; i++) begin
            wait_cnt_d[i] = wait_cnt_q[i];
        end

        // Counts only consecutive no-guard RUN cycles; any fire restarts it.
        if (!bus.io_clear && (state_q == ST_RUN) && (state_d == ST_RUN) && !any_guard_s) begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end else begin
            idle_cnt_d = {CNT_W{1'b0}};
        end

        for (int i = 0; i < N_RULES; i++) begin
            if (bus.io_clear) begin
                wait_cnt_d[i] = {WAIT_W{1'b0}};
            end else if (state_q == ST_HALT) begin
                wait_cnt_d[i] = wait_cnt_q[i];
            end else if (bus.io_guard[i] && !en_s[i]) begin
                if (wait_cnt_q[i] == WAIT_MAX) begin
                    wait_cnt_d[i] = WAIT_MAX;
                end else begin
                    wait_cnt_d[i] = wait_cnt_q[i] + WAIT_W'(1);
                end
            end else begin
                wait_cnt_d[i] = {WAIT_W{1'b0}};
            end
            starved_d[i] = (32'(wait_cnt_d[i]) >= 32'(STARVE_LIMIT));
        end
    end

    // State, pointer and monitor registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= {IDX_W{1'b0}};
            idle_cnt_q <= {CNT_W{1'b0}};
            starved_q  <= {N_RULES{1'b0}};
            for (int i = 0; i < N_RULES; i++) begin
                wait_cnt_q[i] <= {WAIT_W{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idle_cnt_q <= idle_cnt_d;
            starved_q  <= starved_d;
            for (int i = 0; i < N_RULES; i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end

    assign bus.io_en_a     = en_s;
    assign bus.io_fired    = fire_s;
    assign bus.io_rule_idx = fire_s ? cand_s : {IDX_W{1'b0}};
    assign bus.io_starved  = starved_q;
    assign bus.io_deadlock = (state_q == ST_HALT);

endmodule

// File: tb/tb_rule_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rule_scheduler
// Directed bench for rule_scheduler built with N_RULES=3, WAIT_W=4,
// STARVE_LIMIT=2, DEADLOCK_CYC=4. Inputs change 1 ns after a rising edge and
// outputs are sampled 1 ns later, well away from the next edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rule_scheduler;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    rule_scheduler_if #(.N_RULES(3)) bus ();

    rule_scheduler #(
        .N_RULES      (3),
        .WAIT_W       (4),
        .STARVE_LIMIT (2),
        .DEADLOCK_CYC (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset        = 1'b1;
        bus.io_guard = 3'b000;
        bus.io_run   = 1'b0;
        bus.io_step  = 1'b0;
        bus.io_clear = 1'b0;

        // Outputs while in reset
        #2;
        check("rst_en",       32'(bus.io_en_a),     32'd0);
        check("rst_fired",    32'(bus.io_fired),    32'd0);
        check("rst_idx",      32'(bus.io_rule_idx), 32'd0);
        check("rst_starved",  32'(bus.io_starved),  32'd0);
        check("rst_deadlock", 32'(bus.io_deadlock), 32'd0);

        // Release reset, request RUN
        #10;
        reset      = 1'b0;
        bus.io_run = 1'b1;
        #1;
        check("idle_en", 32'(bus.io_en_a), 32'd0);

        // Round robin with all guards true: 001, 010, 100, 001
        next_cycle();
        bus.io_guard = 3'b111;
        #1;
        check("rr1_en",      32'(bus.io_en_a),     32'b001);
        check("rr1_idx",     32'(bus.io_rule_idx), 32'd0);
        check("rr1_fired",   32'(bus.io_fired),    32'd1);
        check("rr1_starved", 32'(bus.io_starved),  32'b000);
        next_cycle();
        check("rr2_en",      32'(bus.io_en_a),     32'b010);
        check("rr2_idx",     32'(bus.io_rule_idx), 32'd1);
        check("rr2_fired",   32'(bus.io_fired),    32'd1);
        next_cycle();
        check("rr3_en",      32'(bus.io_en_a),     32'b100);
        check("rr3_idx",     32'(bus.io_rule_idx), 32'd2);
        check("rr3_starved", 32'(bus.io_starved),  32'b100);
        next_cycle();
        check("rr4_en",      32'(bus.io_en_a),     32'b001);
        check("rr4_idx",     32'(bus.io_rule_idx), 32'd0);
        check("rr4_starved", 32'(bus.io_starved),  32'b001);

        // ptr=1, guards 101 -> rule 2, then wrap to rule 0
        next_cycle();
        bus.io_guard = 3'b101;
        #1;
        check("skip_en",  32'(bus.io_en_a),     32'b100);
        check("skip_idx", 32'(bus.io_rule_idx), 32'd2);
        // Dropping io_run still grants in this cycle
        next_cycle();
        bus.io_run = 1'b0;
        #1;
        check("wrap_en", 32'(bus.io_en_a), 32'b001);

        // IDLE single step (ptr=1), guards 010
        next_cycle();
        bus.io_guard = 3'b010;
        bus.io_step  = 1'b1;
        #1;
        check("step_en",    32'(bus.io_en_a),     32'b010);
        check("step_idx",   32'(bus.io_rule_idx), 32'd1);
        check("step_fired", 32'(bus.io_fired),    32'd1);
        next_cycle();
        bus.io_step = 1'b0;
        #1;
        check("step_after_en",    32'(bus.io_en_a),  32'b000);
        check("step_after_fired", 32'(bus.io_fired), 32'd0);
        // Step with no true guard is dropped; ptr stays 2
        next_cycle();
        bus.io_guard = 3'b000;
        bus.io_step  = 1'b1;
        #1;
        check("step_noguard_en", 32'(bus.io_en_a), 32'b000);
        next_cycle();
        bus.io_guard = 3'b111;
        #1;
        check("step_ptr_kept_en",  32'(bus.io_en_a),     32'b100);
        check("step_ptr_kept_idx", 32'(bus.io_rule_idx), 32'd2);

        // Deadlock: RUN with no guards for 4 cycles
        next_cycle();
        bus.io_step  = 1'b0;
        bus.io_guard = 3'b000;
        bus.io_run   = 1'b1;
        #1;
        check("dl_idle_en", 32'(bus.io_en_a), 32'b000);
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            check("dl_run_en",       32'(bus.io_en_a),     32'b000);
            check("dl_run_deadlock", 32'(bus.io_deadlock), 32'd0);
        end
        next_cycle();
        bus.io_guard = 3'b111;
        #1;
        check("dl_deadlock", 32'(bus.io_deadlock), 32'd1);
        check("dl_halt_en",  32'(bus.io_en_a),     32'b000);
        check("dl_halt_fired", 32'(bus.io_fired),  32'd0);
        next_cycle();
        bus.io_clear = 1'b1;
        #1;
        check("dl_clear_same", 32'(bus.io_deadlock), 32'd1);
        next_cycle();
        bus.io_clear = 1'b0;
        #1;
        check("dl_cleared",   32'(bus.io_deadlock), 32'd0);
        check("dl_cleared_en", 32'(bus.io_en_a),    32'b000);
        // Held io_run re-enters RUN one cycle later, ptr=0
        next_cycle();
        check("rerun_en", 32'(bus.io_en_a), 32'b001);
        next_cycle();
        check("rerun2_en",      32'(bus.io_en_a),    32'b010);
        check("rerun2_starved", 32'(bus.io_starved), 32'b110);

        // Asynchronous reset mid-cycle while running
        #1;
        reset = 1'b1;
        #1;
        check("arst_en",       32'(bus.io_en_a),     32'b000);
        check("arst_fired",    32'(bus.io_fired),    32'd0);
        check("arst_starved",  32'(bus.io_starved),  32'b000);
        check("arst_deadlock", 32'(bus.io_deadlock), 32'd0);
        #3;
        reset = 1'b0;
        #1;
        check("post_rst_idle_en", 32'(bus.io_en_a), 32'b000);
        next_cycle();
        check("post_rst_run_en",  32'(bus.io_en_a),     32'b001);
        check("post_rst_run_idx", 32'(bus.io_rule_idx), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
